line_buf_sched: RTL and testbench
=================================

Name: line_buf_sched

Overview:
- Scheduler for the double-buffered display line buffer. The buffer is one single-port BRAM of depth 2*DISPLAY_WIDTH, split into two halves.
- While the renderer fills one half, scanout reads the other half. The halves swap at the start of each line.
- Sits between the renderer write stream, video timing/scanout, and the BRAM port. Arbitrates the single BRAM port and owns the half-select (disp_sel).

Parameters:
- ADDR_WIDTH, 32, BRAM address width.
- DISPLAY_WIDTH, 640, pixels per line (W); each half holds W entries.
- DATA_WIDTH, 24, pixel width (3 colours x 8 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse from video timing at the start of each active line.
- pix_req  in  1  scanout requests the next pixel.
- pix_data  out  DATA_WIDTH  pixel returned to scanout.
- pix_valid  out  1  pix_data valid.
- wr_valid  in  1  renderer pixel valid.
- wr_ready  out  1  pixel accepted this cycle when wr_valid && wr_ready.
- wr_data  in  DATA_WIDTH  renderer pixel.
- wr_last  in  1  marks the last pixel of a rendered line.
- disp_sel  out  1  half being displayed (0: addresses 0..W-1, 1: W..2W-1); the fill half is ~disp_sel.
- fill_done  out  1  fill half complete, waiting for a swap.
- swap  out  1  one-cycle pulse when the halves swap.
- underrun  out  1  one-cycle pulse on line_start while the fill is incomplete.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_dout  in  DATA_WIDTH  BRAM read data; 1-cycle read latency.

Behaviour:
- State:
  - rd_x: read counter, 0..W; W means the line is exhausted.
  - wr_x: write counter, 0..W-1.
  - Fill FSM with states FILLING and FULL.
- Reset: disp_sel=0, FSM=FILLING, rd_x=0, wr_x=0. pix_valid, pix_data, swap and underrun are 0. bram_en=bram_we=0. A read in flight at reset is squashed: no pix_valid after reset.
- Per-cycle arbitration on the single port, in priority order:
  1. line_start cycle: no read is issued (the pix_req that cycle is dropped). A write is still allowed under rule 3.
  2. Read when pix_req && rd_x<W. Drive bram_en=1, bram_we=0, bram_addr=disp_sel*W+rd_x. Then rd_x++.
  3. Otherwise write when FSM=FILLING && wr_valid. Drive bram_en=1, bram_we=1, bram_addr=(~disp_sel)*W+wr_x, bram_din=wr_data.
- wr_ready is combinational: FSM=FILLING && !(read issued this cycle).
- Addresses are computed at ADDR_WIDTH; W*2 must fit in ADDR_WIDTH.
- pix_valid=1 exactly one cycle after a read is issued, with pix_data=bram_dout.
- pix_req with rd_x==W issues no access and produces no pix_valid.
- Accepted write:
  - If wr_last || wr_x==W-1: FSM goes to FULL and wr_x holds.
  - Otherwise wr_x++.
  - wr_last before W-1 ends the line early; the remaining entries keep stale data.
- fill_done = (FSM==FULL). wr_ready=0 while FULL.
- line_start with FSM=FULL, or with a write completing the line in the same cycle:
  - disp_sel toggles next cycle; swap=1 for 1 cycle.
  - FSM goes to FILLING; wr_x=0 and rd_x=0.
- line_start with FSM=FILLING and no completion that cycle:
  - underrun=1 for 1 cycle; disp_sel is unchanged and the old line is redisplayed.
  - rd_x=0; wr_x continues (the fill is not restarted).
- A write accepted in the same cycle as a swap targets the pre-swap fill half.
- A read issued in the cycle before a swap returns its pixel normally.
- wr_valid while FULL: not accepted and no state change.

Test Plan:
(W=8 override)
- Reset, renderer streams 8 pixels 0x10..0x17 with no pix_req: BRAM writes to addresses 8..15 on 8 consecutive cycles, fill_done=1 after the 8th. Then line_start gives swap=1 and disp_sel=1.
- After the swap, hold pix_req for 9 cycles: reads at addresses 8..15, pix_data 0x10..0x17 with pix_valid lagging 1 cycle. The 9th request issues no access and gives no pix_valid.
- pix_req and wr_valid held together: reads win, wr_ready=0, and no write occurs until rd_x==8. Then writes resume at address 0.
- line_start after only 5 of 8 writes: underrun=1, disp_sel unchanged, rd_x restarts at 0. The 6th write lands at fill address base+5.
- wr_last on the 3rd pixel: FULL after 3 writes. line_start then swaps, and addresses 3..7 of the new display half hold stale data.
- Final write (wr_x=7) in the same cycle as line_start: swap=1 that cycle and underrun=0. Also assert rst mid-read: no pix_valid next cycle, disp_sel=0.

Source files
------------

// File: rtl/line_buf_sched_if.sv
// Bundle of the renderer write stream, scanout request/return, line-buffer
// status and the single BRAM port seen by the line buffer scheduler.
// The scheduler uses the slave view; the surrounding system uses the master view.
interface line_buf_sched_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 32
);
    // video timing / scanout side
    logic                  line_start;
    logic                  pix_req;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;

    // renderer write stream
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;

    // buffer status
    logic                  disp_sel;
    logic                  fill_done;
    logic                  swap;
    logic                  underrun;

    // single-port BRAM
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport master (
        output line_start, pix_req, wr_valid, wr_data, wr_last, bram_dout,
        input  pix_data, pix_valid, wr_ready, disp_sel, fill_done, swap,
               underrun, bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        input  line_start, pix_req, wr_valid, wr_data, wr_last, bram_dout,
        output pix_data, pix_valid, wr_ready, disp_sel, fill_done, swap,
               underrun, bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/line_buf_sched.sv
// Double-buffered display line buffer scheduler.
// One single-port BRAM of depth 2*DISPLAY_WIDTH is split into two halves:
// scanout reads the half selected by disp_sel while the renderer fills the
// other one. Reads always win the port; writes use any cycle left over.
// 2*DISPLAY_WIDTH must be representable in ADDR_WIDTH bits.
module line_buf_sched #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DISPLAY_WIDTH = 640,
    parameter int DATA_WIDTH    = 24
) (
    input logic             clk,
    input logic             rst,
    line_buf_sched_if.slave bus
);

    localparam int CW = $clog2(DISPLAY_WIDTH + 1);
    localparam logic [CW-1:0]         W_CNT  = CW'(DISPLAY_WIDTH);
    localparam logic [CW-1:0]         LAST_X = CW'(DISPLAY_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] W_ADDR = ADDR_WIDTH'(DISPLAY_WIDTH);

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_t;

    fill_state_t     state;
    logic [CW-1:0]   rd_x;
    logic [CW-1:0]   wr_x;
    logic            disp_sel_q;
    logic            swap_q;
    logic            underrun_q;
    logic            rd_pending;

    logic            rd_issue;
    logic            wr_accept;
    logic            wr_complete;
    logic            do_swap;
    logic            do_underrun;
    logic [ADDR_WIDTH-1:0] disp_base;
    logic [ADDR_WIDTH-1:0] fill_base;

    // Port arbitration: line_start blocks reads, reads beat writes, and a
    // swap happens when the fill is already full or completes this very cycle.
    always_comb begin
        rd_issue    = !rst && !bus.line_start && bus.pix_req && (rd_x < W_CNT);
        wr_accept   = !rst && (state == FILLING) && bus.wr_valid && !rd_issue;
        wr_complete = wr_accept && (bus.wr_last || (wr_x == LAST_X));
        do_swap     = !rst && bus.line_start && ((state == FULL) || wr_complete);
        do_underrun = !rst && bus.line_start && !do_swap;
        disp_base   = disp_sel_q ? W_ADDR : '0;
        fill_base   = disp_sel_q ? '0 : W_ADDR;
    end

    // Drive the BRAM port for whichever access won this cycle.
    always_comb begin
        bus.bram_en   = 1'b0;
        bus.bram_we   = 1'b0;
        bus.bram_addr = '0;
        bus.bram_din  = '0;
        if (rd_issue) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = disp_base + ADDR_WIDTH'(rd_x);
        end else if (wr_accept) begin
            bus.bram_en   = 1'b1;
            bus.bram_we   = 1'b1;
            bus.bram_addr = fill_base + ADDR_WIDTH'(wr_x);
            bus.bram_din  = bus.wr_data;
        end
    end

    // Fill FSM, read/write counters, half select and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILLING;
            rd_x       <= '0;
            wr_x       <= '0;
            disp_sel_q <= 1'b0;
            swap_q     <= 1'b0;
            underrun_q <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            swap_q     <= do_swap;
            underrun_q <= do_underrun;

            if (rd_issue) begin
                rd_x <= rd_x + 1'b1;
            end

            if (wr_accept) begin
                if (wr_complete) begin
                    state <= FULL;
                end else begin
                    wr_x <= wr_x + 1'b1;
                end
            end

            if (do_swap) begin
                disp_sel_q <= ~disp_sel_q;
                state      <= FILLING;
                wr_x       <= '0;
                rd_x       <= '0;
            end else if (do_underrun) begin
                rd_x <= '0;
            end
        end
    end

    assign bus.wr_ready  = !rst && (state == FILLING) && !rd_issue;
    assign bus.fill_done = (state == FULL);
    assign bus.disp_sel  = disp_sel_q;
    assign bus.swap      = swap_q;
    assign bus.underrun  = underrun_q;
    assign bus.pix_valid = rd_pending;
    assign bus.pix_data  = rd_pending ? bus.bram_dout : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed testbench for line_buf_sched with an 8-pixel line and a simple
// 1-cycle-latency single-port BRAM model.
module tb_line_buf_sched;

    localparam int AW = 32;
    localparam int W  = 8;
    localparam int DW = 24;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] mem [0:2*W-1];

    line_buf_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    line_buf_sched #(
        .ADDR_WIDTH   (AW),
        .DISPLAY_WIDTH(W),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.bram_en) begin
            if (bus.bram_we) mem[bus.bram_addr[3:0]] <= bus.bram_din;
            else             bus.bram_dout <= mem[bus.bram_addr[3:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ls, input logic pr, input logic wv,
                                 input logic [DW-1:0] wd, input logic wl);
        bus.line_start = ls;
        bus.pix_req    = pr;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.wr_last    = wl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_stale [0:5];
        exp_stale[0] = 24'h30; exp_stale[1] = 24'h31; exp_stale[2] = 24'h32;
        exp_stale[3] = 24'h13; exp_stale[4] = 24'h14; exp_stale[5] = 24'h15;
        n_checks = 0;
        n_fail   = 0;
        bus.bram_dout = '0;

        // reset: nothing reaches the BRAM while rst is high
        rst = 1'b1;
        applyStimulus(0, 1, 1, 24'h55, 0);
        checkOutput("rst_bram_en", bus.bram_en, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0);
        tick;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_disp_sel", bus.disp_sel, 0);
        checkOutput("rst_fill_done", bus.fill_done, 0);
        checkOutput("rst_pix_valid", bus.pix_valid, 0);
        checkOutput("rst_swap", bus.swap, 0);
        checkOutput("rst_underrun", bus.underrun, 0);
        checkOutput("rst_wr_ready", bus.wr_ready, 1);
        checkOutput("rst_idle_en", bus.bram_en, 0);
        tick;

        // full line of 8 writes into half 1 (addresses 8..15)
        for (int i = 0; i < W; i++) begin
            applyStimulus(0, 0, 1, 24'h10 + DW'(i), 0);
            checkOutput("fill1_we", bus.bram_we, 1);
            checkOutput("fill1_addr", bus.bram_addr, 32'(8 + i));
            checkOutput("fill1_din", bus.bram_din, 32'(24'h10 + i));
            tick;
        end
        applyStimulus(0, 0, 1, 24'h99, 0);
        checkOutput("full_fill_done", bus.fill_done, 1);
        checkOutput("full_wr_ready", bus.wr_ready, 0);
        checkOutput("full_no_write", bus.bram_en, 0);
        tick;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("full_hold", bus.fill_done, 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("swap1_pulse", bus.swap, 1);
        checkOutput("swap1_disp_sel", bus.disp_sel, 1);
        checkOutput("swap1_fill_done", bus.fill_done, 0);
        checkOutput("swap1_underrun", bus.underrun, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("swap1_one_cycle", bus.swap, 0);

        // 9 requests: 8 reads of addresses 8..15, the 9th is ignored
        for (int j = 0; j < 9; j++) begin
            applyStimulus(0, 1, 0, 0, 0);
            if (j < W) begin
                checkOutput("rd2_en", bus.bram_en, 1);
                checkOutput("rd2_addr", bus.bram_addr, 32'(8 + j));
                checkOutput("rd2_wr_ready", bus.wr_ready, 0);
            end else begin
                checkOutput("rd2_exhausted_en", bus.bram_en, 0);
            end
            if (j == 0) begin
                checkOutput("rd2_first_valid", bus.pix_valid, 0);
            end else begin
                checkOutput("rd2_valid", bus.pix_valid, 1);
                checkOutput("rd2_data", bus.pix_data, 32'(24'h10 + j - 1));
            end
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rd2_no_extra_valid", bus.pix_valid, 0);
        tick;

        // line_start with an empty fill: underrun, line redisplayed
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("ls_drops_read", bus.bram_en, 0);
        tick;

        // reads and writes contend: reads win until the line is exhausted
        for (int k = 0; k < W; k++) begin
            applyStimulus(0, 1, 1, 24'h20, 0);
            if (k == 0) begin
                checkOutput("ur1_pulse", bus.underrun, 1);
                checkOutput("ur1_disp_sel", bus.disp_sel, 1);
                checkOutput("ur1_swap", bus.swap, 0);
            end
            checkOutput("arb_we", bus.bram_we, 0);
            checkOutput("arb_addr", bus.bram_addr, 32'(8 + k));
            checkOutput("arb_wr_ready", bus.wr_ready, 0);
            tick;
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 1, 24'h20 + DW'(k), 0);
            checkOutput("arb_wr_we", bus.bram_we, 1);
            checkOutput("arb_wr_addr", bus.bram_addr, 32'(k));
            checkOutput("arb_wr_ready", bus.wr_ready, 1);
            tick;
        end

        // line_start after 5 of 8 writes
        applyStimulus(1, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("ur2_pulse", bus.underrun, 1);
        checkOutput("ur2_disp_sel", bus.disp_sel, 1);
        checkOutput("ur2_rd_restart", bus.bram_addr, 32'd8);
        tick;
        applyStimulus(0, 0, 1, 24'h25, 0);
        checkOutput("ur2_wr_continue", bus.bram_addr, 32'd5);
        checkOutput("ur2_wr_we", bus.bram_we, 1);
        checkOutput("ur2_one_cycle", bus.underrun, 0);
        tick;
        applyStimulus(0, 0, 1, 24'h26, 0);
        checkOutput("wr6_addr", bus.bram_addr, 32'd6);
        tick;

        // last write of the line coincides with line_start
        applyStimulus(1, 0, 1, 24'h27, 0);
        checkOutput("lastwr_addr", bus.bram_addr, 32'd7);
        checkOutput("lastwr_ready", bus.wr_ready, 1);
        tick;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("swap2_pulse", bus.swap, 1);
        checkOutput("swap2_underrun", bus.underrun, 0);
        checkOutput("swap2_disp_sel", bus.disp_sel, 0);
        checkOutput("swap2_rd_addr", bus.bram_addr, 32'd0);
        tick;
        for (int k = 1; k <= W; k++) begin
            applyStimulus(0, (k < W) ? 1'b1 : 1'b0, 0, 0, 0);
            checkOutput("rd3_valid", bus.pix_valid, 1);
            checkOutput("rd3_data", bus.pix_data, 32'(24'h20 + k - 1));
            tick;
        end

        // wr_last on the 3rd pixel into half 1
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 24'h30 + DW'(i), (i == 2) ? 1'b1 : 1'b0);
            checkOutput("short_addr", bus.bram_addr, 32'(8 + i));
            tick;
        end
        applyStimulus(0, 0, 1, 24'h77, 0);
        checkOutput("short_fill_done", bus.fill_done, 1);
        checkOutput("short_no_write", bus.bram_en, 0);
        tick;
        applyStimulus(1, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("swap3_pulse", bus.swap, 1);
        checkOutput("swap3_disp_sel", bus.disp_sel, 1);
        tick;

        // read back the short line: entries 3.. hold the older line's pixels
        for (int j = 0; j < 6; j++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("rd4_addr", bus.bram_addr, 32'(8 + j));
            if (j > 0) checkOutput("rd4_data", bus.pix_data, 32'(exp_stale[j-1]));
            tick;
        end

        // reset while a read is being requested
        rst = 1'b1;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rst2_no_access", bus.bram_en, 0);
        checkOutput("rst2_prev_data", bus.pix_data, 32'(exp_stale[5]));
        tick;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst2_pix_valid", bus.pix_valid, 0);
        checkOutput("rst2_disp_sel", bus.disp_sel, 0);
        checkOutput("rst2_fill_done", bus.fill_done, 0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
